// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : Fetch-side beat and execute-side control bundle of the decode stage.
// Revision : 1.0
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      out_alu_control;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_alu_src;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_jump;
    logic [2:0]      out_mem_size;
    logic            out_illegal;

    // master: the environment around the stage (fetch + execute)
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_control, out_rs1, out_rs2,
               out_rd, out_imm, out_alu_src, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_jump, out_mem_size, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_control, out_rs1, out_rs2,
               out_rd, out_imm, out_alu_src, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_jump, out_mem_size, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32I decoder with optional skid buffer, flush and
//            saturating decoded/illegal counters.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] decoded_count,
    output logic [CNT_W-1:0] illegal_count
);
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b0110;
    localparam logic [3:0] c_ALU_SRL  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;
    localparam logic [3:0] c_ALU_PASS = 4'b1010;
    localparam logic [3:0] c_ALU_INV  = 4'b1111;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      alu;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [2:0]      mem_size;
        logic            illegal;
    } bundle_t;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm32;
    bundle_t     w_dec;
    bundle_t     w_skid;
    logic        w_skid_full;
    logic        w_out_free;
    logic        w_accept;
    logic        w_out_fire;

    bundle_t          r_out;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    assign w_instr  = bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];

    always_comb begin
        w_dec       = '0;
        w_dec.pc    = bus.in_pc;
        w_dec.rs1   = w_instr[19:15];
        w_dec.rs2   = w_instr[24:20];
        w_dec.rd    = w_instr[11:7];
        w_dec.alu   = c_ALU_ADD;
        w_imm32     = {{20{w_instr[31]}}, w_instr[31:20]};
        case (w_opcode)
            c_OP_R: begin
                w_dec.reg_write = 1'b1;
                case ({w_f7, w_f3})
                    10'b0000000_000: w_dec.alu = c_ALU_ADD;
                    10'b0100000_000: w_dec.alu = c_ALU_SUB;
                    10'b0000000_001: w_dec.alu = c_ALU_SLL;
                    10'b0000000_010: w_dec.alu = c_ALU_SLT;
                    10'b0000000_011: w_dec.alu = c_ALU_SLTU;
                    10'b0000000_100: w_dec.alu = c_ALU_XOR;
                    10'b0000000_101: w_dec.alu = c_ALU_SRL;
                    10'b0100000_101: w_dec.alu = c_ALU_SRA;
                    10'b0000000_110: w_dec.alu = c_ALU_OR;
                    10'b0000000_111: w_dec.alu = c_ALU_AND;
                    default:         w_dec.illegal = 1'b1;
                endcase
            end
            c_OP_IMM: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
                case (w_f3)
                    3'b000: w_dec.alu = c_ALU_ADD;
                    3'b010: w_dec.alu = c_ALU_SLT;
                    3'b011: w_dec.alu = c_ALU_SLTU;
                    3'b100: w_dec.alu = c_ALU_XOR;
                    3'b110: w_dec.alu = c_ALU_OR;
                    3'b111: w_dec.alu = c_ALU_AND;
                    3'b001: begin
                        w_dec.alu     = c_ALU_SLL;
                        w_dec.illegal = (w_f7 != 7'b0000000);
                    end
                    default: begin
                        w_dec.alu     = (w_f7 == 7'b0100000) ? c_ALU_SRA : c_ALU_SRL;
                        w_dec.illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                endcase
            end
            c_OP_LOAD: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.mem_size  = w_f3;
                w_dec.illegal   = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_OP_STORE: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.mem_size  = w_f3;
                w_dec.illegal   = w_f3[2] || (w_f3 == 3'b011);
                w_imm32         = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            c_OP_BR: begin
                w_dec.alu     = c_ALU_SUB;
                w_dec.branch  = 1'b1;
                w_dec.illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                w_imm32       = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                                 w_instr[30:25], w_instr[11:8], 1'b0};
            end
            c_OP_JAL: begin
                w_dec.jump      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_imm32         = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                                   w_instr[20], w_instr[30:21], 1'b0};
            end
            c_OP_JALR: begin
                w_dec.jump      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.illegal   = (w_f3 != 3'b000);
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_dec.alu       = (w_opcode == c_OP_LUI) ? c_ALU_PASS : c_ALU_ADD;
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_imm32         = {w_instr[31:12], 12'b0};
            end
            default: w_dec.illegal = 1'b1;
        endcase
        w_dec.imm = XLEN'($signed(w_imm32));
        // Illegal beats must not have any architectural side effect downstream
        if (w_dec.illegal) begin
            w_dec.alu       = c_ALU_INV;
            w_dec.alu_src   = 1'b0;
            w_dec.reg_write = 1'b0;
            w_dec.mem_read  = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.branch    = 1'b0;
            w_dec.jump      = 1'b0;
            w_dec.mem_size  = 3'b000;
        end
        if (w_dec.rd == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_accept   = bus.in_valid && bus.in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic    r_skid_full;
            bundle_t r_skid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid_full <= 1'b0;
                    r_skid      <= '0;
                end else if (flush || w_out_free) begin
                    r_skid_full <= 1'b0;
                end else if (w_accept) begin
                    r_skid_full <= 1'b1;
                    r_skid      <= w_dec;
                end
            end

            assign w_skid_full  = r_skid_full;
            assign w_skid       = r_skid;
            assign bus.in_ready = !r_skid_full && !rst;
        end else begin : g_no_skid
            assign w_skid_full  = 1'b0;
            assign w_skid       = '0;
            assign bus.in_ready = w_out_free && !rst;
        end
    endgenerate

    // The skid entry is older than any incoming beat, so it drains first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            if (w_skid_full) begin
                r_out       <= w_skid;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_dec_cnt != '1) begin
                r_dec_cnt <= r_dec_cnt + c_CNT_ONE;
            end
            if (r_out.illegal && (r_ill_cnt != '1)) begin
                r_ill_cnt <= r_ill_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.out_valid       = r_out_valid;
    assign bus.out_pc          = r_out.pc;
    assign bus.out_alu_control = r_out.alu;
    assign bus.out_rs1         = r_out.rs1;
    assign bus.out_rs2         = r_out.rs2;
    assign bus.out_rd          = r_out.rd;
    assign bus.out_imm         = r_out.imm;
    assign bus.out_alu_src     = r_out.alu_src;
    assign bus.out_reg_write   = r_out.reg_write;
    assign bus.out_mem_read    = r_out.mem_read;
    assign bus.out_mem_write   = r_out.mem_write;
    assign bus.out_branch      = r_out.branch;
    assign bus.out_jump        = r_out.jump;
    assign bus.out_mem_size    = r_out.mem_size;
    assign bus.out_illegal     = r_out.illegal;
    assign decoded_count       = r_dec_cnt;
    assign illegal_count       = r_ill_cnt;
endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage for the pipelined core. It sits between fetch and execute and accepts one instruction plus PC per valid/ready beat. It produces a full control bundle one cycle later: ALU op, register indices, sign-extended immediate, memory, branch and jump controls, and an illegal-instruction flag. It adds a parametrised skid buffer, a flush input, and saturating decode/illegal counters.

## Interface
- XLEN, 32: datapath width for PC and immediate; legal values are 32 and 64, and the immediate is sign-extended to XLEN.
- SKID, 1: 1 = two-entry (output register plus skid register), so in_ready is registered; 0 = single output register, so in_ready is combinational.
- CNT_W, 16: width of the decoded and illegal counters.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming beats this cycle.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  PC of the bundle.
- out_alu_control  out  4  ALU op: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 sra, 0111 srl, 1000 slt, 1001 sltu, 1010 pass-B, 1111 invalid.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_src  out  1  1 = ALU operand B is the immediate.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each  control strobes.
- out_mem_size  out  3  func3 of the load/store.
- out_illegal  out  1  instruction is illegal.
- decoded_count, illegal_count  out  CNT_W each  saturating counters.

## Operation
- Decode runs combinationally on in_instr and the result is registered when a beat is accepted (in_valid && in_ready).
- R-type (0110011): the ALU op comes from {func7, func3}. Legal func7 values are 0000000 for all func3, and 0100000 for func3 000 (sub) and 101 (sra). Any other combination is illegal. alu_src=0, reg_write=1.
- OP-IMM (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai. Shifts require imm[11:5] of 0000000, or 0100000 for srai. alu_src=1, reg_write=1.
- LOAD (0000011): legal func3 values are 000, 001, 010, 100, 101. Controls: add, alu_src=1, mem_read=1, reg_write=1, mem_write=0.
- STORE (0100011): legal func3 values are 000–010. Controls: add, alu_src=1, mem_write=1, reg_write=0, S-immediate.
- BRANCH (1100011): func3 010 and 011 are illegal. Controls: branch=1, ALU op sub, B-immediate.
- JAL (1101111): jump=1, reg_write=1, J-immediate.
- JALR (1100111): func3 must be 000; jump=1, reg_write=1, alu_src=1, I-immediate.
- LUI (0110111): pass-B, alu_src=1, reg_write=1, U-immediate.
- AUIPC (0010111): add, alu_src=1, reg_write=1, U-immediate.
- Any other opcode is illegal.
- Illegal beat: out_illegal=1, ALU op 1111, and every write, read, branch and jump strobe is 0. Indices and PC pass through unchanged.
- rd = x0 forces reg_write=0. This does not make the instruction illegal.
- Counters:
  - decoded_count increments on each output handshake (out_valid && out_ready).
  - illegal_count increments on an output handshake that carries out_illegal=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Latency: a beat accepted at edge N is presented on out_* after edge N, i.e. in cycle N+1.
- in_ready:
  - SKID=1: in_ready = !skid_full, taken from a register.
  - SKID=0: in_ready = !out_valid || out_ready.
- Skid rules (SKID=1):
  - If a beat is accepted while out_valid && !out_ready, it goes into the skid register.
  - When the output drains, the skid content moves to the output register on the next edge.
  - A new beat may be accepted in that same cycle only if the skid register is then empty.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated except by flush.
- out_* must hold stable while out_valid && !out_ready.
- flush:
  - Clears out_valid and skid_full at the edge.
  - A beat offered in the flush cycle is discarded.
  - in_ready is 1 in the following cycle.
  - An output handshake in the flush cycle still counts.
  - flush has priority over acceptance.
- rst: overrides flush and all traffic.
  - in_ready is 0 while rst is asserted.
  - Reset values: out_valid=0, skid empty, all out_* = 0, out_alu_control=0000, both counters 0.
  - Asserting rst mid-stall drops held beats.

## Test plan
- Streaming: send add x3,x1,x2 (0x002081B3) with out_ready=1. One cycle later expect alu_control=0000, rd=3, rs1=1, rs2=2, reg_write=1, alu_src=0, decoded_count=1.
- Immediates: lw x5,-4(x2) (0xFFC12283) -> out_imm=0xFFFFFFFC, mem_read=1, mem_size=010. With XLEN=64 the immediate is 0xFFFFFFFFFFFFFFFC. beq with offset -8 -> imm=-8, branch=1.
- Backpressure: hold out_ready=0 and offer 3 beats. SKID=1 accepts 2 and then in_ready=0. After release the beats appear in order over consecutive cycles with no loss; repeat with SKID=0.
- Illegal: opcode 1111111, and R-type func7=0100000 with func3=111 -> out_illegal=1, alu_control=1111, all strobes 0, illegal_count increments.
- Flush during stall: with output and skid both full, pulse flush with in_valid=1. Next cycle out_valid=0 and in_ready=1, and no flushed beat ever appears.
- Reset and saturation: with CNT_W=4, stream 20 beats -> decoded_count stays at 15. Assert rst mid-stall -> all outputs and counters are 0 on the next cycle.
